// File: rtl/fc_input_loader_if.sv
// fc_input_loader_if
// Bundles the two handshakes of the FC input loader:
//   - upstream activation stream : s_valid, s_ready, s_data, s_last
//   - parallel vector to FC layer: x[0:IN-1], x_valid, x_ready
// Modports:
//   master - the environment side (drives the stream, consumes x)
//   slave  - the loader itself
interface fc_input_loader_if #(
  parameter int WIDTH = 8,
  parameter int IN    = 400
);
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             s_last;
  logic [WIDTH-1:0] x [0:IN-1];
  logic             x_valid;
  logic             x_ready;

  modport master (
    output s_valid, s_data, s_last, x_ready,
    input  s_ready, x, x_valid
  );

  modport slave (
    input  s_valid, s_data, s_last, x_ready,
    output s_ready, x, x_valid
  );
endinterface

// File: rtl/fc_input_loader.sv
// fc_input_loader
// Streaming-to-parallel front end for the fully connected layers. Beats of
// WIDTH bits are collected into IN-element vectors in two ping-pong banks;
// a finished bank is presented as x[0:IN-1] with x_valid until released by
// x_ready, while the other bank fills.
// Ports:
//   i_clk        rising-edge clock
//   i_rst        synchronous active-high reset (control state only)
//   bus          fc_input_loader_if.slave (stream in, vector out)
//   o_frame_err  one-cycle pulse after a mis-framed beat
//   o_drop_cnt   saturating count of dropped short vectors
module fc_input_loader #(
  parameter int WIDTH = 8,
  parameter int IN    = 400
) (
  input  logic                i_clk,
  input  logic                i_rst,
  fc_input_loader_if.slave    bus,
  output logic                o_frame_err,
  output logic [7:0]          o_drop_cnt
);

  localparam int CW = (IN > 1) ? $clog2(IN) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(IN - 1);

  // Bank storage (never reset; contents only matter while marked full)
  logic [WIDTH-1:0] r_bank0 [0:IN-1];
  logic [WIDTH-1:0] r_bank1 [0:IN-1];

  // Control state
  logic          r_wr_bank;
  logic          r_rd_bank;
  logic [CW-1:0] r_count;
  logic [1:0]    r_full;
  logic          r_frame_err;
  logic [7:0]    r_drop_cnt;

  // Next-state and handshake wires
  logic          w_s_ready;
  logic          w_accept;
  logic          w_at_end;
  logic          w_release;
  logic          w_wr_bank_nxt;
  logic          w_rd_bank_nxt;
  logic [CW-1:0] w_count_nxt;
  logic [1:0]    w_full_nxt;
  logic          w_frame_err_nxt;
  logic [7:0]    w_drop_cnt_nxt;

  // Handshake outputs depend only on registered flags, so there is no
  // combinational path from s_valid to s_ready or from x_ready to x_valid.
  assign w_s_ready   = ~r_full[r_wr_bank];
  assign bus.s_ready = w_s_ready;
  assign bus.x_valid = r_full[r_rd_bank];
  assign o_frame_err = r_frame_err;
  assign o_drop_cnt  = r_drop_cnt;

  // Present the read bank as the parallel vector
  always_comb begin
    for (int k = 0; k < IN; k++) begin
      bus.x[k] = r_rd_bank ? r_bank1[k] : r_bank0[k];
    end
  end

  // Next-state logic for fill position, bank flags and error reporting
  always_comb begin
    w_accept        = bus.s_valid && w_s_ready;
    w_at_end        = (r_count == LAST_IDX);
    w_release       = r_full[r_rd_bank] && bus.x_ready;
    w_wr_bank_nxt   = r_wr_bank;
    w_rd_bank_nxt   = r_rd_bank;
    w_count_nxt     = r_count;
    w_full_nxt      = r_full;
    w_frame_err_nxt = 1'b0;
    w_drop_cnt_nxt  = r_drop_cnt;

    if (w_accept) begin
      if (w_at_end) begin
        // Element IN-1 always completes the vector; a missing s_last is
        // flagged but the vector is still delivered.
        w_full_nxt[r_wr_bank] = 1'b1;
        w_wr_bank_nxt         = ~r_wr_bank;
        w_count_nxt           = {CW{1'b0}};
        w_frame_err_nxt       = ~bus.s_last;
      end else if (bus.s_last) begin
        // Short frame: discard the partial vector, bank stays empty
        w_count_nxt     = {CW{1'b0}};
        w_frame_err_nxt = 1'b1;
        w_drop_cnt_nxt  = (r_drop_cnt == 8'hFF) ? 8'hFF : (r_drop_cnt + 8'd1);
      end else begin
        w_count_nxt = r_count + CW'(1);
      end
    end else begin
      w_count_nxt = r_count;
    end

    // A release targets the read bank, which can never be the bank being
    // completed in the same cycle, so both updates apply independently.
    if (w_release) begin
      w_full_nxt[r_rd_bank] = 1'b0;
      w_rd_bank_nxt         = ~r_rd_bank;
    end else begin
      w_rd_bank_nxt = r_rd_bank;
    end
  end

  // Control state register with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_count     <= {CW{1'b0}};
      r_full      <= 2'b00;
      r_frame_err <= 1'b0;
      r_drop_cnt  <= 8'd0;
    end else begin
      r_wr_bank   <= w_wr_bank_nxt;
      r_rd_bank   <= w_rd_bank_nxt;
      r_count     <= w_count_nxt;
      r_full      <= w_full_nxt;
      r_frame_err <= w_frame_err_nxt;
      r_drop_cnt  <= w_drop_cnt_nxt;
    end
  end

  // Write accepted beats into the bank currently being filled
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      if (r_wr_bank) begin
        r_bank1[r_count] <= bus.s_data;
      end else begin
        r_bank0[r_count] <= bus.s_data;
      end
    end
  end

endmodule

// File: tb/tb_fc_input_loader.sv
module tb_fc_input_loader;
  localparam int WIDTH = 8;
  localparam int IN    = 400;
  localparam int VW    = IN * WIDTH;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_err;
  logic [7:0] drop_cnt;

  fc_input_loader_if #(.WIDTH(WIDTH), .IN(IN)) bus ();

  fc_input_loader #(.WIDTH(WIDTH), .IN(IN)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .bus         (bus),
    .o_frame_err (frame_err),
    .o_drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_err_cyc = -10;
  int mcount = 0;
  int exp_drop = 0;
  logic [VW-1:0] mbuf;
  logic [VW-1:0] q [$];

  always @(posedge clk) cyc++;

  // Scoreboard monitor: samples mid-cycle, away from the rising edge
  logic [VW-1:0] exp_v;
  int nbad;
  int first_bad;
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      assert (bus.x_valid === (q.size() > 0)) else begin
        errors++;
        $error("FAIL x_valid got %b exp %b (cyc %0d)", bus.x_valid, (q.size() > 0), cyc);
      end
      checks++;
      assert (bus.s_ready === (q.size() < 2)) else begin
        errors++;
        $error("FAIL s_ready got %b exp %b (cyc %0d)", bus.s_ready, (q.size() < 2), cyc);
      end
      checks++;
      assert (frame_err === (last_err_cyc == cyc)) else begin
        errors++;
        $error("FAIL frame_err got %b exp %b (cyc %0d)", frame_err, (last_err_cyc == cyc), cyc);
      end
      checks++;
      assert (drop_cnt === 8'(exp_drop)) else begin
        errors++;
        $error("FAIL drop_cnt got %0d exp %0d (cyc %0d)", drop_cnt, exp_drop, cyc);
      end
      if (bus.x_valid && bus.x_ready && q.size() > 0) begin
        exp_v = q.pop_front();
        nbad = 0;
        first_bad = -1;
        for (int k = 0; k < IN; k++) begin
          if (bus.x[k] !== exp_v[k*WIDTH +: WIDTH]) begin
            nbad++;
            if (first_bad < 0) first_bad = k;
          end
        end
        checks++;
        assert (nbad == 0) else begin
          errors++;
          $error("FAIL x_data got %0d bad elems (first idx %0d: %h) exp 0 bad (exp %h)",
                 nbad, first_bad, bus.x[(first_bad < 0) ? 0 : first_bad],
                 exp_v[((first_bad < 0) ? 0 : first_bad)*WIDTH +: WIDTH]);
        end
      end
    end
  end

  // Reference model of one accepted beat
  task automatic model_accept(input logic [WIDTH-1:0] d, input logic last);
    if (mcount == IN - 1) begin
      mbuf[mcount*WIDTH +: WIDTH] = d;
      q.push_back(mbuf);
      mcount = 0;
      if (!last) last_err_cyc = cyc;
    end else if (last) begin
      mcount = 0;
      last_err_cyc = cyc;
      if (exp_drop < 255) exp_drop++;
    end else begin
      mbuf[mcount*WIDTH +: WIDTH] = d;
      mcount++;
    end
  endtask

  // Drive one beat and wait (bounded) for it to be accepted
  task automatic send(input logic [WIDTH-1:0] d, input logic last);
    bit ok;
    bit rdy;
    ok = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
    for (int t = 0; t < 3000 && !ok; t++) begin
      @(negedge clk);
      rdy = bus.s_ready;
      @(posedge clk);
      if (rdy) ok = 1'b1;
    end
    #1;
    checks++;
    assert (ok) else begin
      errors++;
      $error("FAIL accept_timeout got 0 exp 1");
    end
    if (ok) model_accept(d, last);
  endtask

  task automatic send_vec(input int n, input int last_at, input int mul, input int off);
    for (int i = 0; i < n; i++) begin
      send(8'((i * mul + off) % 256), (i == last_at));
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic drain();
    bus.x_ready = 1'b1;
    for (int t = 0; t < 3000 && q.size() > 0; t++) @(negedge clk);
    @(posedge clk);
    #1;
    checks++;
    assert (q.size() == 0) else begin
      errors++;
      $error("FAIL drain_timeout got %0d pending exp 0", q.size());
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    q.delete();
    mcount = 0;
    exp_drop = 0;
    last_err_cyc = -10;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    bus.x_ready = 1'b0;
    mbuf = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic vector, data = index mod 256, consumer always ready
    bus.x_ready = 1'b1;
    send_vec(400, 399, 1, 0);
    drain();

    // Two back-to-back vectors held, then released in order
    bus.x_ready = 1'b0;
    send_vec(400, 399, 3, 7);
    send_vec(400, 399, 5, 11);
    repeat (5) @(posedge clk);
    #1;
    drain();

    // Short frame (s_last on beat 99) then an intact vector
    send_vec(100, 99, 1, 50);
    send_vec(400, 399, 7, 1);
    drain();

    // Missing s_last on beat 399, then an aligned vector
    send_vec(400, -1, 9, 2);
    send_vec(400, 399, 1, 100);
    drain();

    // Reset mid-fill with vector 0 pending
    bus.x_ready = 1'b0;
    send_vec(400, 399, 2, 3);
    send_vec(200, -1, 13, 4);
    do_reset();
    bus.x_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    send_vec(400, 399, 11, 5);
    drain();

    // Drop counter saturation
    for (int i = 0; i < 260; i++) begin
      send_vec(1, 0, 1, i);
    end
    repeat (4) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fc_input_loader.md
# fc_input_loader

Streaming-to-parallel front end for the fully connected neuron layers. It accepts one WIDTH-bit activation per beat over a valid/ready stream and assembles complete IN-element vectors. Each finished vector is presented as the parallel array `x[0:IN-1]` that the combinational FC layer consumes, together with a valid/ready handshake. Two ping-pong banks let the next vector fill while the current one is held for the layer and its downstream register.

## Interface
- WIDTH, 8, activation bit width; matches layer WIDTH
- IN, 400, elements per vector; matches layer IN
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- s_valid  input  1  upstream beat valid
- s_ready  output  1  loader can accept a beat
- s_data  input  WIDTH  activation value, element order 0..IN-1
- s_last  input  1  marks the final element of a vector
- x  output  WIDTH x [0:IN-1]  assembled vector (unpacked array, index 0 = first beat)
- x_valid  output  1  x holds a complete vector
- x_ready  input  1  consumer accepts x this cycle
- frame_err  output  1  one-cycle pulse on framing error
- drop_cnt  output  8  saturating count of dropped vectors

## Operation
- Clock and reset are fixed: one clock (`clk`); `rst` is synchronous and active-high.
- State registers:
  - bank0 and bank1, each IN x WIDTH
  - wr_bank and rd_bank (1 bit each)
  - count, $clog2(IN) bits
  - full[1:0]
- Combinational outputs:
  - s_ready = ~full[wr_bank]
  - x_valid = full[rd_bank]
  - x = bank[rd_bank]
- A beat is accepted when s_valid && s_ready. On acceptance, s_data is written to bank[wr_bank][count].
- Accepted beat with count < IN-1 and s_last=0: count increments.
- Accepted beat with count == IN-1, regardless of s_last:
  - full[wr_bank] is set, wr_bank toggles, count returns to 0.
  - If s_last=0, frame_err pulses for one cycle. The vector is still delivered; the next beat starts a new vector.
- Accepted beat with count < IN-1 and s_last=1 (short frame):
  - The partial vector is dropped: count returns to 0 and the bank is not marked full.
  - frame_err pulses and drop_cnt increments, saturating at 255.
- Output release: when x_valid && x_ready, full[rd_bank] is cleared and rd_bank toggles.
- A vector completion and a release in the same cycle are both applied. They always target different banks.
- While x_valid=1 and x_ready=0, x and x_valid hold stable.
- x contents are don't-care while x_valid=0.
- Bank storage is not reset. Only control state is reset.

## Timing
- Reset values, seen in the cycle after rst is sampled high:
  - count=0, wr_bank=0, rd_bank=0, full=2'b00
  - s_ready=1, x_valid=0, frame_err=0, drop_cnt=0
- Reset takes priority over every other event, including a mid-frame fill or a pending x: the partial vector and both full flags are discarded.
- Latency: the last beat accepted at edge N gives x_valid=1 in the cycle following edge N.
- Throughput: 1 beat/cycle sustained when the consumer releases each vector within IN cycles of it becoming valid.
- Back-pressure: with both banks full, s_ready=0 until the first release; s_ready returns to 1 in the cycle after the release edge.
- frame_err is registered: high for exactly the one cycle after the offending beat.
- No combinational path from s_valid to s_ready, nor from x_ready to x_valid.

## Test plan
- Reset, then 400 beats with s_data = index mod 256 and s_last on beat 399; x_ready=1 → x_valid rises the cycle after beat 399; x[k]=k mod 256; frame_err stays 0.
- Two back-to-back vectors with x_ready=0 → s_ready drops after beat 799 (both banks full); raising x_ready releases vector 0 and then vector 1 in order, each with its correct contents.
- s_last on beat 99 → frame_err pulses once, drop_cnt=1, no x_valid; the following 400-beat vector is delivered intact.
- Beat 399 sent without s_last → vector delivered, frame_err pulses once; the next vector is aligned from element 0.
- rst asserted at beat 200 of the second fill while vector 0 is pending → x_valid=0, s_ready=1, count=0; a fresh 400-beat vector then emerges correctly.
- 260 short frames → drop_cnt saturates at 255.
